mul_sequencer: RTL and testbench

- Iterative 24x24 shift-add multiply controller for the 24-bit CPU.
- Accepts a multiply command from decode and sequences one partial-product step per clock.
- Applies sign correction for signed operations, then writes the 48-bit product into MulReg through a one-cycle write strobe.
- Stalls the pipeline when a product read (HI/LO move) arrives while a multiply is in flight.

---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_step.sv | 22 ++
 rtl/mul_sequencer.sv | 110 +++++++++++
 tb/tb_mul_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative 24x24 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

  localparam int WIDTH  = 24;
  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } mulState_t;

  typedef logic [PROD_W-1:0] prod_t;

  // Absolute value of an operand when it is treated as signed; raw value otherwise.
  // The most negative value maps to 2^(WIDTH-1), which is exact as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add partial-product iteration.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when to register the result.
module mul_step
  import mul_pkg::*;
(
  input  prod_t            accIn,
  input  prod_t            mcandIn,
  input  logic [WIDTH-1:0] mplierIn,
  output prod_t            accOut,
  output prod_t            mcandOut,
  output logic [WIDTH-1:0] mplierOut
);

  // Add the aligned multiplicand when the current multiplier bit is set, then shift both operands.
  always_comb begin
    accOut    = mplierIn[0] ? (accIn + mcandIn) : accIn;
    mcandOut  = {mcandIn[PROD_W-2:0], 1'b0};
    mplierOut = {1'b0, mplierIn[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative 24x24 multiply controller: one shift-add step per clock, sign fix-up, MulReg write.
// Latency: Start at edge E0 -> one-cycle write strobe in cycle 25, MulReg captures at E25.
// Backpressure: Start ignored while busy; Stall holds decode when it reads MulReg mid-multiply.
module mul_sequencer
  import mul_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Signed,
  input  logic [WIDTH-1:0]  OpA,
  input  logic [WIDTH-1:0]  OpB,
  input  logic              ReadReq,
  output logic              Busy,
  output logic              Done,
  output logic              Stall,
  output logic              MulWriteEn,
  output logic [PROD_W-1:0] MulWriteData
);

  mulState_t        state;
  mulState_t        nextState;
  logic [CNT_W-1:0] stepCnt;
  prod_t            acc;
  prod_t            mcand;
  logic [WIDTH-1:0] mplier;
  logic             negResult;
  prod_t            prodReg;

  prod_t            accNext;
  prod_t            mcandNext;
  logic [WIDTH-1:0] mplierNext;
  logic             lastStep;

  mul_step uStep (
    .accIn     (acc),
    .mcandIn   (mcand),
    .mplierIn  (mplier),
    .accOut    (accNext),
    .mcandOut  (mcandNext),
    .mplierOut (mplierNext)
  );

  // The step being taken on this edge is the final one of WIDTH iterations.
  assign lastStep = (stepCnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: IDLE waits for Start, RUN counts WIDTH steps, WRITE lasts one cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = RUN;
      RUN:     if (lastStep) nextState = WRITE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: latch magnitudes on accept, iterate in RUN, and capture the sign-corrected
  // product on the last step so it is stable for the whole WRITE cycle and held afterwards.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stepCnt   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      negResult <= 1'b0;
      prodReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand     <= PROD_W'(magnitude(OpA, Signed));
            mplier    <= magnitude(OpB, Signed);
            negResult <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            acc       <= '0;
            stepCnt   <= '0;
          end
        end
        RUN: begin
          acc     <= accNext;
          mcand   <= mcandNext;
          mplier  <= mplierNext;
          stepCnt <= stepCnt + CNT_W'(1);
          if (lastStep) begin
            // Negating zero yields zero, so a zero operand with mixed signs stays 0.
            prodReg <= negResult ? ((~accNext) + PROD_W'(1)) : accNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy         = (state != IDLE);
  assign Done         = (state == WRITE);
  assign MulWriteEn   = (state == WRITE);
  assign MulWriteData = prodReg;
  // A read issued alongside Start in IDLE is not stalled: it returns the previous product.
  assign Stall        = ReadReq & Busy;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a MulReg model fed by the write strobe.
// Latency: checks the exact E0 -> E24 write cycle -> E25 capture timing.
// Backpressure: exercises ignored Start, read stalls and mid-operation reset.
module tb_mul_sequencer;
  import mul_pkg::*;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic              Signed = 1'b0;
  logic [WIDTH-1:0]  OpA = '0;
  logic [WIDTH-1:0]  OpB = '0;
  logic              ReadReq = 1'b0;
  logic              Busy;
  logic              Done;
  logic              Stall;
  logic              MulWriteEn;
  logic [PROD_W-1:0] MulWriteData;

  int    vecCount = 0;
  int    missCount = 0;
  int    wePulses = 0;
  int    weBase;
  prod_t mulReg = '0;

  mul_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .Signed       (Signed),
    .OpA          (OpA),
    .OpB          (OpB),
    .ReadReq      (ReadReq),
    .Busy         (Busy),
    .Done         (Done),
    .Stall        (Stall),
    .MulWriteEn   (MulWriteEn),
    .MulWriteData (MulWriteData)
  );

  always #5 Clock = ~Clock;

  // MulReg model: captures only on the write strobe and is untouched by the block's reset.
  always @(posedge Clock) begin
    if (MulWriteEn) begin
      mulReg   <= MulWriteData;
      wePulses <= wePulses + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after an edge; presents a command and returns 1ns after the accepting edge E0.
  task automatic issue(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    Signed = sgn;
    OpA    = a;
    OpB    = b;
    Start  = 1'b1;
    @(posedge Clock);
    #1;
    Start  = 1'b0;
  endtask

  // Full multiply with timing checks: busy after E0, no strobe after E23, strobe after E24,
  // MulReg updated and idle after E25.
  task automatic doMul(input string tag, input logic sgn, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input prod_t exp);
    issue(sgn, a, b);
    checkVal({tag, " busy"}, 48'(Busy), 48'd1);
    repeat (23) @(posedge Clock);
    #1;
    checkVal({tag, " early"}, 48'(Done), 48'd0);
    @(posedge Clock);
    #1;
    checkVal({tag, " we"}, 48'(MulWriteEn & Done), 48'd1);
    checkVal({tag, " data"}, MulWriteData, exp);
    @(posedge Clock);
    #1;
    checkVal({tag, " idle"}, 48'(Busy), 48'd0);
    checkVal({tag, " mulreg"}, mulReg, exp);
  endtask

  initial begin
    // Reset state while held in reset.
    #12;
    checkVal("rst busy", 48'(Busy), 48'd0);
    checkVal("rst done", 48'(Done), 48'd0);
    checkVal("rst stall", 48'(Stall), 48'd0);
    checkVal("rst we", 48'(MulWriteEn), 48'd0);
    checkVal("rst data", MulWriteData, 48'd0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    doMul("u5x7", 1'b0, 24'd5, 24'd7, 48'd35);
    // 3*5 = 15, negated over 48 bits.
    doMul("s-3x5", 1'b1, 24'hFFFFFD, 24'd5, 48'hFFFF_FFFF_FFF1);
    // 0xFFFFFD * 5 = 0x5000000 - 15 = 0x4FFFFF1.
    doMul("u-3x5", 1'b0, 24'hFFFFFD, 24'd5, 48'h0000_04FF_FFF1);
    // (2^24-1)^2 = 2^48 - 2^25 + 1.
    doMul("umax", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001);
    // (-2^23)^2 = 2^46.
    doMul("smin", 1'b1, 24'h800000, 24'h800000, 48'h4000_0000_0000);
    doMul("s0xm1", 1'b1, 24'd0, 24'hFFFFFF, 48'd0);

    // Start pulsed in cycle 10 while busy must be ignored.
    weBase = wePulses;
    issue(1'b0, 24'd9, 24'd3);
    repeat (9) @(posedge Clock);
    #1;
    Signed = 1'b0;
    OpA    = 24'd2;
    OpB    = 24'd2;
    Start  = 1'b1;
    @(posedge Clock);
    #1;
    Start  = 1'b0;
    repeat (13) @(posedge Clock);
    #1;
    checkVal("ign early", 48'(Done), 48'd0);
    @(posedge Clock);
    #1;
    checkVal("ign we", 48'(MulWriteEn), 48'd1);
    checkVal("ign data", MulWriteData, 48'd27);
    @(posedge Clock);
    #1;
    checkVal("ign mulreg", mulReg, 48'd27);
    repeat (5) @(posedge Clock);
    #1;
    checkVal("ign idle", 48'(Busy), 48'd0);
    checkVal("ign pulses", 48'(wePulses - weBase), 48'd1);

    // Read together with Start in IDLE is not stalled.
    Signed  = 1'b0;
    OpA     = 24'd4;
    OpB     = 24'd4;
    Start   = 1'b1;
    ReadReq = 1'b1;
    #1;
    checkVal("rdstart stall", 48'(Stall), 48'd0);
    @(posedge Clock);
    #1;
    Start   = 1'b0;
    ReadReq = 1'b0;
    // ReadReq held from cycle 3 stalls through WRITE and releases at E25.
    repeat (2) @(posedge Clock);
    #1;
    ReadReq = 1'b1;
    #1;
    checkVal("rd stall c3", 48'(Stall), 48'd1);
    repeat (21) @(posedge Clock);
    #1;
    checkVal("rd stall e23", 48'(Stall), 48'd1);
    @(posedge Clock);
    #1;
    checkVal("rd stall wr", 48'(Stall & Done), 48'd1);
    checkVal("rd data", MulWriteData, 48'd16);
    @(posedge Clock);
    #1;
    checkVal("rd stall e25", 48'(Stall), 48'd0);
    checkVal("rd mulreg", mulReg, 48'd16);
    ReadReq = 1'b0;

    // Reset between edges during iteration 10 aborts with no write.
    weBase = wePulses;
    issue(1'b0, 24'd100, 24'd100);
    repeat (9) @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    checkVal("abort busy", 48'(Busy), 48'd0);
    checkVal("abort we", 48'(MulWriteEn), 48'd0);
    checkVal("abort data", MulWriteData, 48'd0);
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    checkVal("abort pulses", 48'(wePulses - weBase), 48'd0);
    checkVal("abort mulreg", mulReg, 48'd16);
    doMul("u6x6", 1'b0, 24'd6, 24'd6, 48'd36);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
